// File: rtl/ahb_bcd_converter_pkg.sv
// Shared constants, register offsets and FSM encoding for the AHB binary-to-BCD converter.
package ahb_bcd_converter_pkg;

  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;
  localparam int BCD_W  = DIGITS * 4;

  localparam logic [31:0]      BCD_MAX   = 32'd99_999_999;
  localparam logic [BCD_W-1:0] BCD_SAT   = 32'h9999_9999;
  localparam logic [4:0]       LAST_ITER = 5'(BIN_W - 1);

  typedef enum logic [1:0] {
    REG_BIN  = 2'd0,
    REG_BCD  = 2'd1,
    REG_STAT = 2'd2,
    REG_RSVD = 2'd3
  } reg_off_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

endpackage

// File: rtl/ahb_bcd_converter_if.sv
// AHB-Lite signal bundle between the CPU bus and the BCD converter slave.
interface ahb_bcd_converter_if;

  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HWDATA,
    output HRDATA, HREADYOUT
  );

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HWDATA,
    input  HRDATA, HREADYOUT
  );

endinterface

// File: rtl/ahb_bcd_converter_bcd_dabble_digit.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_dabble_digit (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // The largest legal input is 9, so the result (12) never leaves 4 bits.
    always_comb begin
        adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end

endmodule

// File: rtl/ahb_bcd_converter.sv
// AHB-Lite slave converting a written binary value into 8 packed BCD digits,
// one double-dabble iteration per clock, with a glitch-free result register.
module ahb_bcd_converter
    import ahb_bcd_converter_pkg::*;
(
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_bcd_converter_if.slave   ahb,
    output logic [BCD_W-1:0]     bcd_out,
    output logic                 bcd_valid,
    output logic                 conv_done
);

    reg_off_e           addr_q;
    logic               wr_q;
    logic               bin_write;

    state_e             state,  state_n;
    logic [4:0]         cnt,    cnt_n;
    logic [BIN_W-1:0]   shreg,  shreg_n;
    logic [BIN_W-1:0]   bin_q,  bin_n;
    logic [BCD_W-1:0]   acc,    acc_n;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   bcd_n;
    logic               ovf,    ovf_n;
    logic               valid_n;
    logic               done_n;

    logic               unused_bits;

    assign unused_bits   = ^{ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HTRANS[0]};
    assign ahb.HREADYOUT = 1'b1;

    // Address phase: remember which register the following data phase targets.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q <= REG_BIN;
            wr_q   <= 1'b0;
        end else if (ahb.HREADY) begin
            addr_q <= reg_off_e'(ahb.HADDR[3:2]);
            wr_q   <= ahb.HSEL & ahb.HWRITE & ahb.HTRANS[1];
        end
    end

    assign bin_write = wr_q && (addr_q == REG_BIN);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_dabble_digit u_digit (
            .digit    (acc[4*i +: 4]),
            .adjusted (adj[4*i +: 4])
        );
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        acc_n   = acc;
        bin_n   = bin_q;
        ovf_n   = ovf;
        bcd_n   = bcd_out;
        valid_n = bcd_valid;
        done_n  = 1'b0;

        // A new BIN write always wins, even over a completion on the same edge.
        if (bin_write) begin
            bin_n   = ahb.HWDATA[BIN_W-1:0];
            ovf_n   = ahb.HWDATA > BCD_MAX;
            shreg_n = ahb.HWDATA[BIN_W-1:0];
            acc_n   = '0;
            cnt_n   = '0;
            state_n = ST_CONV;
        end else if (state == ST_CONV) begin
            {acc_n, shreg_n} = {adj, shreg} << 1;
            cnt_n            = cnt + 5'd1;
            if (cnt == LAST_ITER) begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                bcd_n   = ovf ? BCD_SAT : acc_n;
                valid_n = 1'b1;
                done_n  = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            acc       <= '0;
            bin_q     <= '0;
            ovf       <= 1'b0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            conv_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            acc       <= acc_n;
            bin_q     <= bin_n;
            ovf       <= ovf_n;
            bcd_out   <= bcd_n;
            bcd_valid <= valid_n;
            conv_done <= done_n;
        end
    end

    always_comb begin
        ahb.HRDATA = '0;
        case (addr_q)
            REG_BIN:  ahb.HRDATA = {{(32-BIN_W){1'b0}}, bin_q};
            REG_BCD:  ahb.HRDATA = bcd_out;
            REG_STAT: ahb.HRDATA = {30'b0, ovf, state == ST_CONV};
            default:  ahb.HRDATA = '0;
        endcase
    end

endmodule
